// File: rtl/fetch_stage.sv
// Instruction fetch stage: keeps one instruction-memory request outstanding at a time
// and feeds the IF/ID register. Handles stall, flush, halt and memory timeout.
module fetch_stage #(
    parameter int unsigned MEM_TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] pc_in,
    input  logic [15:0] pc_plus2_in,
    input  logic        stall,
    input  logic        flush,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic        imem_ack,
    input  logic [15:0] imem_rdata,
    output logic        pc_advance,
    output logic        if_id_valid,
    output logic [15:0] if_id_instr,
    output logic [15:0] if_id_pc_plus2,
    output logic        halted,
    output logic        fetch_err
);

    localparam int unsigned DW    = 16;
    localparam int unsigned CNT_W = $clog2(MEM_TIMEOUT + 1);

    localparam logic [3:0]       OP_HLT   = 4'hF;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_WAIT   = 2'd1,
        S_HALTED = 2'd2,
        S_ERR    = 2'd3
    } state_t;

    state_t           r_state;
    logic             r_req;
    logic [DW-1:0]    r_addr;
    logic [DW-1:0]    r_tag;
    logic             r_drop_pending;
    logic [CNT_W-1:0] r_tmo_cnt;
    logic             r_halted;
    logic             r_fetch_err;

    logic             r_if_id_valid;
    logic [DW-1:0]    r_if_id_instr;
    logic [DW-1:0]    r_if_id_pc2;
    logic             r_skid_valid;
    logic [DW-1:0]    r_skid_instr;
    logic [DW-1:0]    r_skid_pc2;

    logic w_ack_wait;
    logic w_discard;
    logic w_accept;
    logic w_is_hlt;
    logic w_if_id_free;
    logic w_issue;

    // A response is thrown away if it belongs to a flushed fetch or meets a flush.
    assign w_ack_wait   = (r_state == S_WAIT) && imem_ack;
    assign w_discard    = r_drop_pending || flush;
    assign w_accept     = w_ack_wait && !w_discard;
    assign w_is_hlt     = (imem_rdata[15:12] == OP_HLT);
    assign w_if_id_free = !r_if_id_valid || !stall;
    assign w_issue      = (r_state == S_IDLE) && !r_skid_valid && w_if_id_free && !flush;

    // Request FSM: issue, wait for ack or timeout, terminal halt/error states.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state        <= S_IDLE;
            r_req          <= 1'b0;
            r_addr         <= '0;
            r_tag          <= '0;
            r_drop_pending <= 1'b0;
            r_tmo_cnt      <= '0;
            r_halted       <= 1'b0;
            r_fetch_err    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_issue) begin
                        r_state   <= S_WAIT;
                        r_req     <= 1'b1;
                        r_addr    <= pc_in;
                        r_tag     <= pc_plus2_in;
                        r_tmo_cnt <= '0;
                    end
                end
                S_WAIT: begin
                    if (imem_ack) begin
                        r_req          <= 1'b0;
                        r_drop_pending <= 1'b0;
                        if (w_accept && w_is_hlt) begin
                            r_state  <= S_HALTED;
                            r_halted <= 1'b1;
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end else begin
                        if (flush) begin
                            r_drop_pending <= 1'b1;
                        end
                        if (r_tmo_cnt == CNT_LAST) begin
                            r_state     <= S_ERR;
                            r_req       <= 1'b0;
                            r_fetch_err <= 1'b1;
                        end else begin
                            r_tmo_cnt <= r_tmo_cnt + CNT_W'(1);
                        end
                    end
                end
                S_HALTED, S_ERR: begin
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // IF/ID register and its one-entry skid buffer; flush beats everything.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_if_id_valid <= 1'b0;
            r_if_id_instr <= '0;
            r_if_id_pc2   <= '0;
            r_skid_valid  <= 1'b0;
            r_skid_instr  <= '0;
            r_skid_pc2    <= '0;
        end else if (flush) begin
            r_if_id_valid <= 1'b0;
            r_skid_valid  <= 1'b0;
        end else if (w_accept && w_if_id_free) begin
            r_if_id_valid <= 1'b1;
            r_if_id_instr <= imem_rdata;
            r_if_id_pc2   <= r_tag;
        end else if (w_accept) begin
            r_skid_valid <= 1'b1;
            r_skid_instr <= imem_rdata;
            r_skid_pc2   <= r_tag;
        end else if (r_skid_valid && !stall) begin
            r_if_id_valid <= 1'b1;
            r_if_id_instr <= r_skid_instr;
            r_if_id_pc2   <= r_skid_pc2;
            r_skid_valid  <= 1'b0;
        end else if (r_if_id_valid && !stall) begin
            r_if_id_valid <= 1'b0;
        end
    end

    assign imem_req       = r_req;
    assign imem_addr      = r_addr;
    assign pc_advance     = w_accept;
    assign if_id_valid    = r_if_id_valid;
    assign if_id_instr    = r_if_id_instr;
    assign if_id_pc_plus2 = r_if_id_pc2;
    assign halted         = r_halted;
    assign fetch_err      = r_fetch_err;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios with literal expectations, then random
// traffic checked every cycle against a queue-based model of the fetch stage.
module tb_fetch_stage;

    localparam int MEM_TIMEOUT = 15;

    logic        clk;
    logic        rst;
    logic [15:0] pc_in;
    logic [15:0] pc_plus2_in;
    logic        stall;
    logic        flush;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ack;
    logic [15:0] imem_rdata;
    logic        pc_advance;
    logic        if_id_valid;
    logic [15:0] if_id_instr;
    logic [15:0] if_id_pc_plus2;
    logic        halted;
    logic        fetch_err;

    fetch_stage #(.MEM_TIMEOUT(MEM_TIMEOUT)) dut (
        .clk            (clk),
        .rst            (rst),
        .pc_in          (pc_in),
        .pc_plus2_in    (pc_plus2_in),
        .stall          (stall),
        .flush          (flush),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ack       (imem_ack),
        .imem_rdata     (imem_rdata),
        .pc_advance     (pc_advance),
        .if_id_valid    (if_id_valid),
        .if_id_instr    (if_id_instr),
        .if_id_pc_plus2 (if_id_pc_plus2),
        .halted         (halted),
        .fetch_err      (fetch_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // Model: IF/ID plus skid seen as an in-order queue of at most two entries (head = IF/ID).
    typedef struct packed {
        logic [15:0] instr;
        logic [15:0] pc2;
    } ent_t;

    ent_t        m_q[$];
    bit          m_busy, m_drop, m_halted, m_err;
    logic [15:0] m_addr, m_tag;
    int          m_waited;

    task automatic model_reset();
        m_q.delete();
        m_busy   = 1'b0;
        m_drop   = 1'b0;
        m_halted = 1'b0;
        m_err    = 1'b0;
        m_addr   = 16'h0;
        m_tag    = 16'h0;
        m_waited = 0;
    endtask

    function automatic bit model_adv();
        return m_busy && imem_ack && !(m_drop || flush);
    endfunction

    task automatic model_step(input bit adv);
        int sz;
        bit can_issue;
        ent_t e;
        sz = m_q.size();
        can_issue = !m_busy && !m_halted && !m_err && (sz < 2) && (sz == 0 || !stall) && !flush;
        if (flush) begin
            m_q.delete();
        end else begin
            if (sz > 0 && !stall) void'(m_q.pop_front());
            if (adv) begin
                e.instr = imem_rdata;
                e.pc2   = m_tag;
                m_q.push_back(e);
            end
        end
        if (m_busy) begin
            if (imem_ack) begin
                m_busy = 1'b0;
                m_drop = 1'b0;
                if (adv && imem_rdata[15:12] == 4'hF) m_halted = 1'b1;
            end else begin
                if (flush) m_drop = 1'b1;
                m_waited++;
                if (m_waited >= MEM_TIMEOUT) begin
                    m_err  = 1'b1;
                    m_busy = 1'b0;
                end
            end
        end else if (can_issue) begin
            m_busy   = 1'b1;
            m_addr   = pc_in;
            m_tag    = pc_plus2_in;
            m_waited = 0;
        end
    endtask

    // Compare on the falling edge, then advance the model across the coming rising edge.
    always @(negedge clk) begin
        bit adv;
        if (!rst) begin
            model_reset();
            check("rst_imem_req",  16'(imem_req),    16'h0);
            check("rst_imem_addr", imem_addr,        16'h0);
            check("rst_pc_adv",    16'(pc_advance),  16'h0);
            check("rst_valid",     16'(if_id_valid), 16'h0);
            check("rst_instr",     if_id_instr,      16'h0);
            check("rst_pc2",       if_id_pc_plus2,   16'h0);
            check("rst_halted",    16'(halted),      16'h0);
            check("rst_err",       16'(fetch_err),   16'h0);
        end else begin
            adv = model_adv();
            check("m_imem_req",  16'(imem_req),    16'(m_busy));
            if (m_busy) check("m_imem_addr", imem_addr, m_addr);
            check("m_pc_adv",    16'(pc_advance),  16'(adv));
            check("m_valid",     16'(if_id_valid), 16'(m_q.size() != 0));
            if (m_q.size() != 0) begin
                check("m_instr", if_id_instr,    m_q[0].instr);
                check("m_pc2",   if_id_pc_plus2, m_q[0].pc2);
            end
            check("m_halted",    16'(halted),      16'(m_halted));
            check("m_err",       16'(fetch_err),   16'(m_err));
            model_step(adv);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int  rst_hold, term_cnt, mem_lat, r;
    bit  mem_busy;
    logic [15:0] d;

    initial begin
        rst = 1'b0; stall = 1'b0; flush = 1'b0; pc_in = 16'h0; pc_plus2_in = 16'h0;
        imem_ack = 1'b0; imem_rdata = 16'h0;
        tick(); tick();
        check("reset_req", 16'(imem_req), 16'h0);
        check("reset_instr", if_id_instr, 16'h0);

        // Basic fetch
        rst = 1'b1; pc_in = 16'h0000; pc_plus2_in = 16'h0002;
        tick();
        check("basic_req", 16'(imem_req), 16'h1);
        check("basic_addr", imem_addr, 16'h0000);
        pc_in = 16'h0100; pc_plus2_in = 16'h0102;
        tick(); tick();
        imem_ack = 1'b1; imem_rdata = 16'h1234;
        #1 check("basic_adv", 16'(pc_advance), 16'h1);
        tick();
        imem_ack = 1'b0; stall = 1'b1;
        #1;
        check("basic_valid", 16'(if_id_valid), 16'h1);
        check("basic_instr", if_id_instr, 16'h1234);
        check("basic_pc2", if_id_pc_plus2, 16'h0002);
        check("basic_adv_off", 16'(pc_advance), 16'h0);
        check("basic_req_drop", 16'(imem_req), 16'h0);

        // Stall holds IF/ID and blocks new requests
        tick(); tick();
        check("stall_noreq", 16'(imem_req), 16'h0);
        check("stall_hold", if_id_instr, 16'h1234);
        stall = 1'b0;
        tick();
        check("stall_issue_req", 16'(imem_req), 16'h1);
        check("stall_issue_addr", imem_addr, 16'h0100);
        check("stall_consumed", 16'(if_id_valid), 16'h0);
        stall = 1'b1;
        tick();
        imem_ack = 1'b1; imem_rdata = 16'hABCD;
        tick();
        imem_ack = 1'b0; pc_in = 16'h0200; pc_plus2_in = 16'h0202;
        check("stall_load_instr", if_id_instr, 16'hABCD);
        check("stall_load_pc2", if_id_pc_plus2, 16'h0102);
        tick();
        check("stall_held_noreq", 16'(imem_req), 16'h0);
        check("stall_held_valid", 16'(if_id_valid), 16'h1);
        stall = 1'b0;
        tick();
        check("unstall_valid", 16'(if_id_valid), 16'h0);
        check("unstall_addr", imem_addr, 16'h0200);

        // Flush while a request is in flight
        flush = 1'b1;
        tick();
        flush = 1'b0; pc_in = 16'h0300; pc_plus2_in = 16'h0302;
        tick(); tick();
        imem_ack = 1'b1; imem_rdata = 16'h5555;
        #1 check("flush_no_adv", 16'(pc_advance), 16'h0);
        tick();
        imem_ack = 1'b0;
        check("flush_valid", 16'(if_id_valid), 16'h0);
        check("flush_req_drop", 16'(imem_req), 16'h0);
        tick();
        check("flush_new_req", 16'(imem_req), 16'h1);
        check("flush_new_addr", imem_addr, 16'h0300);

        // Flush coinciding with ack
        tick();
        imem_ack = 1'b1; flush = 1'b1; imem_rdata = 16'h2222;
        #1 check("simul_no_adv", 16'(pc_advance), 16'h0);
        tick();
        imem_ack = 1'b0; flush = 1'b0;
        check("simul_valid", 16'(if_id_valid), 16'h0);
        check("simul_req", 16'(imem_req), 16'h0);

        // Halt
        pc_in = 16'h0400; pc_plus2_in = 16'h0402;
        tick();
        check("hlt_addr", imem_addr, 16'h0400);
        imem_ack = 1'b1; imem_rdata = 16'hF000;
        #1 check("hlt_adv", 16'(pc_advance), 16'h1);
        tick();
        imem_ack = 1'b0;
        check("hlt_valid", 16'(if_id_valid), 16'h1);
        check("hlt_instr", if_id_instr, 16'hF000);
        check("hlt_halted", 16'(halted), 16'h1);
        for (int i = 0; i < 20; i++) begin
            tick();
            check("hlt_noreq", 16'(imem_req), 16'h0);
        end
        check("hlt_sticky", 16'(halted), 16'h1);

        // Timeout
        rst = 1'b0;
        tick();
        rst = 1'b1; pc_in = 16'h0500; pc_plus2_in = 16'h0502;
        tick();
        check("tmo_req", 16'(imem_req), 16'h1);
        repeat (14) tick();
        check("tmo_not_yet", 16'(fetch_err), 16'h0);
        check("tmo_req_held", 16'(imem_req), 16'h1);
        tick();
        check("tmo_err", 16'(fetch_err), 16'h1);
        check("tmo_req_off", 16'(imem_req), 16'h0);
        repeat (3) tick();
        check("tmo_sticky", 16'(fetch_err), 16'h1);

        // Asynchronous reset in WAIT, then a stray ack before the first issue
        rst = 1'b0;
        tick();
        rst = 1'b1; pc_in = 16'h0600; pc_plus2_in = 16'h0602;
        tick(); tick(); tick();
        rst = 1'b0;
        #1;
        check("async_req", 16'(imem_req), 16'h0);
        check("async_addr", imem_addr, 16'h0);
        check("async_err", 16'(fetch_err), 16'h0);
        tick();
        rst = 1'b1; flush = 1'b1; imem_ack = 1'b1; imem_rdata = 16'h1111;
        #1 check("stray_ack_adv", 16'(pc_advance), 16'h0);
        tick();
        imem_ack = 1'b0; flush = 1'b0;
        check("stray_ack_valid", 16'(if_id_valid), 16'h0);
        tick();
        check("post_rst_addr", imem_addr, 16'h0600);

        // Random traffic
        rst_hold = 0; term_cnt = 0; mem_busy = 1'b0; mem_lat = 0;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            tick();
            if (halted || fetch_err) term_cnt++;
            else term_cnt = 0;
            if (rst_hold == 0 && (term_cnt > 10 || $urandom_range(0, 399) == 0)) begin
                rst_hold = 2;
                term_cnt = 0;
            end
            if (rst_hold > 0) begin
                rst = 1'b0;
                rst_hold--;
            end else begin
                rst = 1'b1;
            end
            stall       = ($urandom_range(0, 3) == 0);
            flush       = ($urandom_range(0, 11) == 0);
            pc_in       = 16'($urandom) & 16'hFFFE;
            pc_plus2_in = pc_in + 16'h2;
            imem_ack    = 1'b0;
            if (!rst || !imem_req) begin
                mem_busy = 1'b0;
            end else if (!mem_busy) begin
                mem_busy = 1'b1;
                r = $urandom_range(0, 59);
                mem_lat = (r == 0) ? 20 : (r == 1) ? 14 : (r == 2) ? 15 : $urandom_range(0, 3);
            end
            if (mem_busy) begin
                if (mem_lat == 0) begin
                    d = 16'($urandom);
                    if (d[15:12] == 4'hF) d[15] = 1'b0;
                    if ($urandom_range(0, 29) == 0) d[15:12] = 4'hF;
                    imem_ack   = 1'b1;
                    imem_rdata = d;
                    mem_busy   = 1'b0;
                end else begin
                    mem_lat--;
                end
            end else if (rst && !imem_req && $urandom_range(0, 19) == 0) begin
                imem_ack   = 1'b1;
                imem_rdata = 16'($urandom);
            end
        end
        tick();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
